multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the RISC-V lab datapath (instruction fetch, decode/register file, execute). It replaces hand-driven bench control. Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB states. From the latched opcode, funct3 and funct7 it generates RegWrite, ALUSrc, ALU op, memory strobes, write-back select and PC update controls. It sits between the instruction word from fetch and the control inputs of the fetch, decode and execute stages, and it counts retired instructions.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-high
- run  input  1  level; 1 = sequence instructions, 0 = park in IDLE at next instruction boundary
- ins  input  32  instruction word from fetch stage
- zero  input  1  ALU zero flag from execute stage
- irWrite  output  1  latch ins into internal IR (FETCH)
- RegWrite  output  1  register file write enable
- ALUSrc  output  1  0 = rd2, 1 = imm
- op  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- MemRead  output  1  data memory read
- MemWrite  output  1  data memory write
- Mem2Reg  output  2  wd select: 00 ALU z, 01 memory data, 10 PCp4
- PCWrite  output  1  update PC this cycle
- pcSel  output  2  next PC: 00 PCp4, 01 branch, 10 jTarget
- halt  output  1  sequencer stopped (ecall or illegal)
- illegal  output  1  halt caused by unsupported opcode
- retired  output  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State is registered. All outputs are decoded combinationally from the state and the internal IR (Moore). Outputs not listed for a state are 0.
- IDLE: go to FETCH if run = 1, else stay.
- FETCH: irWrite = 1. The IR captures ins on the clock edge. Next state is DECODE.
- DECODE: no strobes. The next state depends on opcode:
  - 0x33, 0x13, 0x03, 0x23, 0x63: EXEC
  - 0x6F: WB
  - 0x73: HALT
  - any other opcode: HALT with illegal set
- EXEC: ALUSrc = 0 for 0x33 and 0x63, otherwise 1.
  - op for 0x03, 0x23, 0x13: 010.
  - op for 0x63: 110.
  - op for 0x33: by funct3 with funct7[5]. 000/0 gives 010, 000/1 gives 110, 111 gives 000, 110 gives 001, 010 gives 111. Any other combination is illegal: go to HALT.
  - Next state: 0x33 and 0x13 go to WB. 0x03 and 0x23 go to MEM.
  - 0x63 ends the instruction here: PCWrite = 1, pcSel = 01 if zero else 00.
- MEM: op = 010 and ALUSrc = 1 are held.
  - 0x03: MemRead = 1, next state WB.
  - 0x23: MemWrite = 1, PCWrite = 1, pcSel = 00; the instruction ends.
- WB: RegWrite = 1 and PCWrite = 1. ALU op and ALUSrc are held from EXEC.
  - 0x33 and 0x13: Mem2Reg = 00, pcSel = 00.
  - 0x03: Mem2Reg = 01, MemRead = 1 held, pcSel = 00.
  - 0x6F: Mem2Reg = 10, pcSel = 10.
- Instruction end is the cycle with PCWrite = 1. On that edge retired increments by 1. Next state is FETCH if run = 1, else IDLE.
- HALT: halt = 1. Stays in HALT until reset. illegal stays 1 if the halt was caused by an unsupported encoding.

## Timing
- Latency in cycles (FETCH to the instruction-end edge):
  - R-type and I-ALU: 4
  - load: 5
  - store: 4
  - beq: 3
  - jal: 3
- run is sampled only in IDLE and at instruction end. Deasserting run mid-instruction lets the instruction complete.
- reset asserted at any time forces state IDLE, IR = 0 and retired = 0 immediately, without waiting for a clock edge. All outputs go to 0, including halt and illegal. A partially executed instruction is abandoned with no PCWrite.
- On the first clock edge after reset release with run = 1, the state enters FETCH.
- retired wraps from 2^CNT_W−1 to 0 with no flag.
- zero is sampled only in EXEC of 0x63.

## Test plan
- R-type add with run = 1: ins = 0x002081B3 (add x3,x1,x2).
  - States: FETCH → DECODE → EXEC (op = 010, ALUSrc = 0) → WB (RegWrite = 1, Mem2Reg = 00, PCWrite = 1, pcSel = 00).
  - retired 0 → 1 after 4 cycles.
- Load: ins = 0x0000A183 (lw x3,0(x1)).
  - MEM has MemRead = 1.
  - WB has Mem2Reg = 01 and RegWrite = 1.
  - 5 cycles total.
- beq: ins = 0x00208463.
  - With zero = 1: EXEC gives op = 110, PCWrite = 1, pcSel = 01.
  - Repeat with zero = 0: pcSel = 00.
  - RegWrite = 0 throughout.
- jal and store:
  - ins = 0x008000EF: WB has Mem2Reg = 10, pcSel = 10, 3 cycles.
  - ins = 0x0020A023: MEM has MemWrite = 1, RegWrite never set.
- Illegal and halt:
  - ins = 0xFFFFFFFF: DECODE → HALT with halt = 1 and illegal = 1, held for 10 cycles.
  - ins = 0x00000073: halt = 1, illegal = 0.
  - Assert reset: all outputs 0 immediately.
- Reset and run control:
  - Assert reset mid-EXEC: state is IDLE before the next edge, no PCWrite.
  - Drop run during a load: the load completes, then the state is IDLE.
  - Preload retired = 0xFFFF with CNT_W = 16: one retirement wraps it to 0x0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control sequencer for the RISC-V lab datapath
// Moore FSM stepping FETCH/DECODE/EXEC/MEM/WB and counting retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      ins,
    input  logic             zero,
    output logic             irWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       op,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       Mem2Reg,
    output logic             PCWrite,
    output logic [1:0]       pcSel,
    output logic             halt,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LD  = 7'h03;
    localparam logic [6:0] OPC_ST  = 7'h23;
    localparam logic [6:0] OPC_BR  = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;
    localparam logic [6:0] OPC_SYS = 7'h73;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ir;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_f7b5;
    logic [2:0] w_rtype_op;
    logic       w_rtype_ok;
    logic [2:0] w_alu_op;
    logic       w_alu_src;
    logic       w_set_illegal;
    logic       w_unused_ir;

    assign w_opc       = r_ir[6:0];
    assign w_f3        = r_ir[14:12];
    assign w_f7b5      = r_ir[30];
    assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};
    assign retired     = r_retired;

    always_comb begin
        w_rtype_op = 3'b000;
        w_rtype_ok = 1'b1;
        case (w_f3)
            3'b000:  w_rtype_op = w_f7b5 ? 3'b110 : 3'b010;
            3'b111:  w_rtype_op = 3'b000;
            3'b110:  w_rtype_op = 3'b001;
            3'b010:  w_rtype_op = 3'b111;
            default: w_rtype_ok = 1'b0;
        endcase
    end

    // ALU controls depend only on the IR, so EXEC, MEM and WB all see the same values.
    always_comb begin
        w_alu_op  = 3'b000;
        w_alu_src = 1'b0;
        case (w_opc)
            OPC_R:                begin w_alu_op = w_rtype_op; end
            OPC_BR:               begin w_alu_op = 3'b110; end
            OPC_LD, OPC_ST, OPC_I: begin w_alu_op = 3'b010; w_alu_src = 1'b1; end
            default:              begin w_alu_op = 3'b000; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ir      <= 32'h0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (irWrite)       r_ir      <= ins;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (PCWrite)       r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        irWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrc        = 1'b0;
        op            = 3'b000;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        Mem2Reg       = 2'b00;
        PCWrite       = 1'b0;
        pcSel         = 2'b00;
        halt          = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            S_IDLE: if (run) w_next = S_FETCH;
            S_FETCH: begin
                irWrite = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                case (w_opc)
                    OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR: w_next = S_EXEC;
                    OPC_JAL: w_next = S_WB;
                    OPC_SYS: w_next = S_HALT;
                    default: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                ALUSrc = w_alu_src;
                op     = w_alu_op;
                case (w_opc)
                    OPC_R: begin
                        w_next        = w_rtype_ok ? S_WB : S_HALT;
                        w_set_illegal = ~w_rtype_ok;
                    end
                    OPC_I:          w_next = S_WB;
                    OPC_LD, OPC_ST: w_next = S_MEM;
                    OPC_BR: begin
                        PCWrite = 1'b1;
                        pcSel   = zero ? 2'b01 : 2'b00;
                    end
                    default:        w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                ALUSrc = w_alu_src;
                op     = w_alu_op;
                if (w_opc == OPC_LD) begin
                    MemRead = 1'b1;
                    w_next  = S_WB;
                end else begin
                    MemWrite = 1'b1;
                    PCWrite  = 1'b1;
                end
            end
            S_WB: begin
                ALUSrc   = w_alu_src;
                op       = w_alu_op;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (w_opc == OPC_LD) begin
                    Mem2Reg = 2'b01;
                    MemRead = 1'b1;
                end else if (w_opc == OPC_JAL) begin
                    Mem2Reg = 2'b10;
                    pcSel   = 2'b10;
                end
            end
            S_HALT: begin
                halt    = 1'b1;
                illegal = r_illegal;
            end
            default: w_next = S_IDLE;
        endcase
        // Every instruction-end cycle (PCWrite) is where run is re-sampled.
        if (PCWrite) w_next = run ? S_FETCH : S_IDLE;
    end
endmodule
